// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: next-PC select encodings, fetch FSM states and default reset vector
package ifu_fetch_pkg;
  typedef enum logic [1:0] {PC = 2'b00, PC_4 = 2'b01, PC_ARB = 2'b10} pc_sel_e;
  typedef enum logic [1:0] {FETCH = 2'b00, VALID = 2'b01, FAULT = 2'b10} state_e;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit, one outstanding imem request, single-entry instr/pc buffer
// Ports: clk/rst (async active-high); pc_sel/pc_AB next-PC select and target;
//   imem_req/imem_addr/imem_ack/imem_rdata memory handshake;
//   instr_valid/instr_ready/instr/pc decode handoff; misalign sticky fault.
// Option: IFU_MISALIGN_TRAP_EN traps misaligned PC_ARB targets into FAULT; otherwise
//   targets are word-aligned by clearing bits [1:0] and misalign stays 0.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] pc_AB,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        misalign
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, target;
  logic        trap;
  always_comb begin
`ifdef IFU_MISALIGN_TRAP_EN
    target = pc_AB;
    trap = (pc_sel == PC_ARB) && (pc_AB[1:0] != 2'b00);
`else
    target = {pc_AB[31:2], 2'b00};
    trap = 1'b0;
`endif
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    case (state_q)
      FETCH: if (imem_ack) begin
        instr_d = imem_rdata;
        state_d = VALID;
      end
      // pc_sel 11 falls through to the sequential pc + 4
      VALID: if (instr_ready) begin
        pc_d = (pc_sel == PC) ? pc_q : (pc_sel == PC_ARB) ? target : pc_q + 32'd4;
        state_d = trap ? FAULT : FETCH;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_VECTOR;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
    end
  end
  // gated by rst so a request abandoned by reset drops immediately
  assign imem_req = (state_q == FETCH) && !rst;
  assign imem_addr = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instr = instr_q;
  assign pc = pc_q;
`ifdef IFU_MISALIGN_TRAP_EN
  assign misalign = (state_q == FAULT);
`else
  assign misalign = 1'b0;
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed table-driven checks of ifu_fetch fetch/handoff/next-PC behaviour
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [31:0] pc_AB;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        misalign;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [1:0]  sel;
    logic [31:0] ab;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [9];
  ifu_fetch dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .pc_AB(pc_AB),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc), .misalign(misalign)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask
  task automatic fetch(input logic [31:0] d, input int w);
    logic [31:0] a;
    a = imem_addr;
    for (int i = 0; i < w; i++) begin
      check("req_hold", {31'b0, imem_req}, 32'd1);
      check("addr_hold", imem_addr, a);
      tick();
    end
    check("fetch_req", {31'b0, imem_req}, 32'd1);
    check("fetch_valid_low", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    imem_rdata = d;
    tick();
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("valid_after_ack", {31'b0, instr_valid}, 32'd1);
    check("instr_captured", instr, d);
    check("valid_req_low", {31'b0, imem_req}, 32'd0);
    check("valid_pc", pc, a);
  endtask
  task automatic handoff(input logic [1:0] sel, input logic [31:0] ab);
    pc_sel = sel;
    pc_AB = ab;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    pc_sel = 2'b00;
    pc_AB = 32'h0;
    check("handoff_valid_low", {31'b0, instr_valid}, 32'd0);
  endtask
  initial begin
    logic [31:0] hold_i, hold_p;
    vt[0] = '{2'b01, 32'h0, 32'h0000_000C};
    vt[1] = '{2'b00, 32'h0, 32'h0000_000C};
    vt[2] = '{2'b10, 32'h100, 32'h0000_0100};
    vt[3] = '{2'b11, 32'h0, 32'h0000_0104};
    vt[4] = '{2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vt[5] = '{2'b01, 32'h0, 32'h0000_0000};
    vt[6] = '{2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vt[7] = '{2'b11, 32'h0, 32'h0000_0000};
    vt[8] = '{2'b10, 32'h2000, 32'h0000_2000};
    rst = 1'b1;
    pc_sel = 2'b00;
    pc_AB = 32'h0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    tick();
    tick();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    rst = 1'b0;
    #1;
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    fetch(32'h1111_0000, 0);
    handoff(2'b01, 32'h0);
    check("seq_addr4", imem_addr, 32'h4);
    fetch(32'h1111_0004, 0);
    handoff(2'b01, 32'h0);
    check("seq_addr8", imem_addr, 32'h8);
    for (int i = 0; i < 9; i++) begin
      fetch(32'hA000_0000 + i, 0);
      handoff(vt[i].sel, vt[i].ab);
      check($sformatf("vec%0d_addr", i), imem_addr, vt[i].exp);
      check($sformatf("vec%0d_pc", i), pc, vt[i].exp);
    end
    fetch(32'hCAFE_0001, 0);
    hold_i = instr;
    hold_p = pc;
    pc_sel = 2'b10;
    pc_AB = 32'h555;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_instr", instr, hold_i);
      check("stall_pc", pc, hold_p);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    handoff(2'b10, 32'h100);
    check("stall_arb_addr", imem_addr, 32'h100);
    pc_sel = 2'b10;
    pc_AB = 32'h9990;
    fetch(32'hBEEF_0002, 3);
    pc_sel = 2'b00;
    pc_AB = 32'h0;
    check("fetch_ignores_sel", pc, 32'h100);
    imem_ack = 1'b1;
    imem_rdata = 32'h5555_5555;
    tick();
    tick();
    imem_ack = 1'b0;
    check("spurious_ack_instr", instr, 32'hBEEF_0002);
    check("spurious_ack_valid", {31'b0, instr_valid}, 32'd1);
    handoff(2'b11, 32'h0);
    check("sel11_addr", imem_addr, 32'h104);
    tick();
    check("wait_req", {31'b0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("midfetch_rst_req", {31'b0, imem_req}, 32'd0);
    tick();
    check("midfetch_rst_pc", pc, 32'h0);
    check("midfetch_rst_req2", {31'b0, imem_req}, 32'd0);
    rst = 1'b0;
    #1;
    check("release_req", {31'b0, imem_req}, 32'd1);
    check("release_addr", imem_addr, 32'h0);
    fetch(32'h7777_0000, 1);
    handoff(2'b10, 32'h102);
`ifdef IFU_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      check("fault_misalign", {31'b0, misalign}, 32'd1);
      check("fault_req", {31'b0, imem_req}, 32'd0);
      check("fault_pc", pc, 32'h102);
      imem_ack = 1'b1;
      pc_sel = 2'b01;
      instr_ready = 1'b1;
      tick();
    end
    imem_ack = 1'b0;
    pc_sel = 2'b00;
    instr_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("fault_exit_misalign", {31'b0, misalign}, 32'd0);
    check("fault_exit_req", {31'b0, imem_req}, 32'd1);
    check("fault_exit_pc", pc, 32'h0);
`else
    check("align_addr", imem_addr, 32'h100);
    check("align_misalign", {31'b0, misalign}, 32'd0);
    check("align_req", {31'b0, imem_req}, 32'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
